// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder with fixed latency, byte-lane merge/extract and access checks.
// Optional store logging is enabled by defining DM_WRITE_LOG_EN.
module dm_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_byte;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic        w_oor;
    logic        w_mis;
    logic        w_err;
    logic        w_accept;
    logic        w_commit;
    logic [31:0] w_word;
    logic [7:0]  w_lane_byte;
    logic [31:0] w_merged;

`ifdef DM_WRITE_LOG_EN
    logic [31:0] r_pc;
`else
    logic        w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)   w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    if (resp_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

    assign w_accept = (r_state == IDLE) && req_valid;
    // The commit edge is the WAIT cycle with the counter at 0, which also covers LATENCY=1.
    assign w_commit = (r_state == WAIT) && (r_cnt == '0);

    assign w_idx  = r_addr[DEPTH_LOG2+1:2];
    assign w_oor  = |r_addr[31:DEPTH_LOG2+2];
    assign w_mis  = !r_byte && (r_addr[1:0] != 2'b00);
    assign w_err  = w_oor || w_mis;
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_lane_byte = w_word[7:0];
        w_merged    = r_wdata;
        if (r_byte) begin
            w_merged = w_word;
            case (r_addr[1:0])
                2'd0: begin w_lane_byte = w_word[7:0];   w_merged[7:0]   = r_wdata[7:0]; end
                2'd1: begin w_lane_byte = w_word[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
                2'd2: begin w_lane_byte = w_word[23:16]; w_merged[23:16] = r_wdata[7:0]; end
                default: begin w_lane_byte = w_word[31:24]; w_merged[31:24] = r_wdata[7:0]; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef DM_WRITE_LOG_EN
            r_pc    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt   <= LAT_M1;
                r_we    <= req_we;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
`ifdef DM_WRITE_LOG_EN
                r_pc    <= req_pc;
`endif
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err <= w_err;
                if (w_err || r_we)  r_rdata <= '0;
                else if (r_byte)    r_rdata <= {{24{w_lane_byte[7]}}, w_lane_byte};
                else                r_rdata <= w_word;
            end else if (r_state == RESP && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit && r_we && !w_err) begin
            r_mem[w_idx] <= w_merged;
`ifdef DM_WRITE_LOG_EN
            $display("@%h: *%h <= %h", r_pc, {r_addr[31:2], 2'b00}, w_merged);
`endif
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency and response, optionally stall resp_ready for 'hold' cycles.
    task automatic do_req(input string tag, input logic we, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int w;
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = byt;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_we    = $urandom_range(0, 1);
        req_byte  = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_pc    = $urandom;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!resp_valid && n < 20);
        check({tag, ".lat"},   n, 2);
        check({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, ".busy"},  {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
            check({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, ".done_rdata"}, resp_rdata, 32'd0);
        check({tag, ".done_err"},   {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        int seen;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_pc     = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.valid", {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err",   {31'd0, resp_err}, 32'd0);

        do_req("sw10",  1, 0, 32'h10,   32'h1234_5678, 32'h3000, 32'h0,          0, 0);
        do_req("lw10",  0, 0, 32'h10,   32'h0,         32'h3004, 32'h1234_5678,  0, 0);
        do_req("sb11",  1, 1, 32'h11,   32'h0000_00AB, 32'h3004, 32'h0,          0, 0);
        do_req("lw10b", 0, 0, 32'h10,   32'h0,         32'h3008, 32'h1234_AB78,  0, 0);
        do_req("lb11",  0, 1, 32'h11,   32'h0,         32'h300C, 32'hFFFF_FFAB,  0, 0);
        do_req("lb10",  0, 1, 32'h10,   32'h0,         32'h3010, 32'h0000_0078,  0, 0);
        do_req("lb13",  0, 1, 32'h13,   32'h0,         32'h3014, 32'h0000_0012,  0, 0);
        do_req("lw13",  0, 0, 32'h13,   32'h0,         32'h3018, 32'h0,          1, 0);
        do_req("sw4k",  1, 0, 32'h4000, 32'hCAFE_F00D, 32'h301C, 32'h0,          1, 0);
        do_req("lw0",   0, 0, 32'h0,    32'h0,         32'h3020, 32'h0,          0, 0);
        do_req("sw2a",  1, 0, 32'h2A,   32'h5555_5555, 32'h3024, 32'h0,          1, 0);
        do_req("lwtop", 0, 0, 32'h3FFC, 32'h0,         32'h3028, 32'h0,          0, 0);
        do_req("stall", 0, 0, 32'h10,   32'h0,         32'h302C, 32'h1234_AB78,  0, 5);
        do_req("after", 0, 1, 32'h12,   32'h0,         32'h3030, 32'h0000_0034,  0, 0);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid.ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("mid.noresp", seen, 0);
        do_req("lw20", 0, 0, 32'h20, 32'h0, 32'h3040, 32'h0, 0, 0);
        do_req("lw10z", 0, 0, 32'h10, 32'h0, 32'h3044, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
